rr_req_gnt_controller: RTL and testbench
========================================

Name: rr_req_gnt_controller

Overview:
- Round-robin controller that shares one resource among N requesters using a registered req/gnt handshake.
- When the resource is idle, a sampled request is granted on the next clock edge (req |=> gnt).
- A grant is held while the owner keeps its request high, up to a bounded number of cycles.
- Sits between requesting agents and the shared datapath resource; its outputs are the signals the team's SVA properties check.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant (>=1).
- ID_W, $clog2(N), width of the owner index.
- CNT_W, $clog2(MAX_HOLD+1), width of the hold counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N  request vector; a requester holds its bit high until it is done with the resource.
- gnt  output  N  registered one-hot grant vector; all-zero when idle.
- gnt_id  output  ID_W  index of the current owner; valid only while busy=1.
- busy  output  1  high while any grant is asserted (equals |gnt).
- timeout  output  1  one-cycle pulse on the edge where an owner is force-released after MAX_HOLD cycles.

Behaviour:
- Reset (rst=0, asynchronous): gnt=0, gnt_id=0, busy=0, timeout=0, rr pointer=0, hold_cnt=0, state=IDLE. On release of rst, the first evaluation occurs at the next posedge.
- Reset mid-grant: gnt drops immediately (asynchronously) and the pointer returns to 0. No timeout pulse.
- Arbitration: search req starting at index ptr, wrapping modulo N; the first set bit wins. On every new grant, ptr <= (winner+1) mod N.
- IDLE state:
  - If req!=0 at posedge k, then at posedge k+1 gnt=onehot(winner), gnt_id=winner, busy=1, hold_cnt=1, state=BUSY.
  - If req==0, all outputs stay 0.
- BUSY state, evaluated each posedge with owner o:
  - req[o]=1 and hold_cnt<MAX_HOLD: keep the grant, hold_cnt+1.
  - req[o]=0 (normal release):
    - If other requests are pending, hand over directly in the same edge: gnt switches from o to the new winner with no idle cycle, and hold_cnt=1.
    - Otherwise gnt=0, busy=0, state=IDLE.
  - req[o]=1 and hold_cnt==MAX_HOLD (forced release): timeout=1 for exactly one cycle, and req[o] is masked for this arbitration only.
    - If another request is pending, hand over to it.
    - If none is pending, o is re-granted, hold_cnt=1, ptr=(o+1) mod N, and the timeout pulse still occurs.
- Grant invariants:
  - gnt is always zero or one-hot.
  - gnt[i] is never high while req[i] was low at the previous edge.
  - A new grant never appears without a request sampled at the preceding edge.
- Simultaneous events:
  - Owner release and a new request arriving on the same edge: the new request is arbitrated immediately.
  - Release and timeout on the same edge: release wins, and no timeout pulse is issued.
- The hold counter saturates at MAX_HOLD; it never wraps.
- MAX_HOLD=1: every grant lasts one cycle, and timeout pulses whenever the owner still requests.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release with req=0 -> gnt=0, busy=0, timeout=0 for 5 cycles. Assert rst=0 mid-grant -> gnt=0 immediately.
- Single grant latency: req=4'b0100 at edge k -> gnt=4'b0100 and gnt_id=2 at edge k+1. Drop req[2] at edge k+3 -> gnt=0 and busy=0 at edge k+4.
- Round-robin fairness: req=4'b1111 held, each owner releasing after 2 cycles -> grant order 0,1,2,3,0, with back-to-back handover (no idle cycle between owners).
- Timeout with contention: MAX_HOLD=8, req=4'b0011, owner 0 never drops -> after 8 grant cycles timeout=1 for one cycle, and gnt moves to 4'b0010 on the same edge.
- Timeout with no contender: req=4'b0001 held 20 cycles -> timeout pulses at grant cycles 8 and 16, gnt stays 4'b0001 throughout, ptr=1.
- Random stress: 100 cycles of $random req -> SVA checks hold:
  - gnt is zero or one-hot.
  - (req!=0 && !busy) |=> busy.
  - gnt[i] |-> $past(req[i]).
  - timeout is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/rr_req_gnt_controller.sv
// Round-robin owner controller for one shared resource: registered one-hot grant,
// bounded hold time with a one-cycle timeout pulse on forced release.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; any sampled request is granted on the next edge
// BUSY  | one owner holds gnt; hold_cnt counts its consecutive cycles
module rr_req_gnt_controller #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N),
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int IW1 = ID_W + 1;

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic [N-1:0]     arb_req;
    logic             arb_found;
    logic [ID_W-1:0]  arb_winner;
    logic [IW1-1:0]   scan_idx;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
        if (idx == ID_W'(N - 1)) begin
            return '0;
        end
        return idx + ID_W'(1);
    endfunction

    // The current owner is never a candidate: on normal release its bit is
    // already low, and on forced release it must be skipped for this round.
    assign arb_req = req & ~gnt_q;

    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        scan_idx   = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = {1'b0, ptr_q} + IW1'(i);
            if (scan_idx >= IW1'(N)) begin
                scan_idx = scan_idx - IW1'(N);
            end
            if (!arb_found && arb_req[scan_idx[ID_W-1:0]]) begin
                arb_found  = 1'b1;
                arb_winner = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = BUSY;
                    gnt_d   = N'(1) << arb_winner;
                    id_d    = arb_winner;
                    ptr_d   = wrap_inc(arb_winner);
                    hold_d  = CNT_W'(1);
                end
            end
            BUSY: begin
                if (req[id_q] && (hold_q < CNT_W'(MAX_HOLD))) begin
                    hold_d = hold_q + CNT_W'(1);
                end else if (arb_found) begin
                    // Handover with no idle cycle; a still-requesting owner
                    // reaching here was force-released.
                    timeout_d = req[id_q];
                    gnt_d     = N'(1) << arb_winner;
                    id_d      = arb_winner;
                    ptr_d     = wrap_inc(arb_winner);
                    hold_d    = CNT_W'(1);
                end else if (req[id_q]) begin
                    timeout_d = 1'b1;
                    ptr_d     = wrap_inc(id_q);
                    hold_d    = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign busy    = |gnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_req_gnt_controller.sv
// Bench for rr_req_gnt_controller (N=4, MAX_HOLD=8): directed scenarios plus
// random req traffic, all checked against an owner/hold/pointer model.
module tb_rr_req_gnt_controller;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the resource, for how long, and where the search starts.
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    rr_req_gnt_controller #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int rr_search(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        logic [3:0] cand;
        bit         forced;
        int         w;
        m_to = 1'b0;
        if (m_owner >= 0 && r[m_owner] && m_hold < MAX_HOLD) begin
            m_hold++;
            return;
        end
        forced = (m_owner >= 0) && r[m_owner];
        cand   = r;
        if (m_owner >= 0) cand[m_owner] = 1'b0;
        w = rr_search(cand, m_ptr);
        if (forced) m_to = 1'b1;
        if (w >= 0) begin
            m_owner = w;
            m_hold  = 1;
            m_ptr   = (w + 1) % N;
        end else if (forced) begin
            m_hold = 1;
            m_ptr  = (m_owner + 1) % N;
        end else begin
            m_owner = -1;
            m_hold  = 0;
        end
    endfunction

    // Drive req, let one edge happen, advance the model, settle away from the edge.
    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++;
        if ({gnt, busy, timeout, gnt_id} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b busy=%b timeout=%b gnt_id=%0d, required all zero", gnt, busy, timeout, gnt_id);
        end
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(4'b0000);
            total++;
            if ({gnt, busy, timeout} !== 6'b0) begin
                bad++;
                $display("FAIL idle_after_reset cycle %0d: gnt=%b busy=%b timeout=%b, required 0", c, gnt, busy, timeout);
            end
        end
        tick(4'b0001);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL pre_midreset_grant: gnt=%b required 0001", gnt);
        end
        tick(4'b0010);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        total++;
        if ({gnt, busy, timeout} !== 6'b0) begin
            bad++;
            $display("FAIL midgrant_reset: gnt=%b busy=%b timeout=%b, required 0 immediately", gnt, busy, timeout);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Owner 1 was granted before reset (ptr=2); a cleared pointer must pick 0.
        tick(4'b1001);
        total++;
        if (gnt !== 4'b0001 || gnt !== exp_gnt()) begin
            bad++;
            $display("FAIL ptr_after_reset: gnt=%b required 0001", gnt);
        end
    endtask

    task automatic test_single_grant();
        apply_reset();
        tick(4'b0100);
        total++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: gnt=%b gnt_id=%0d busy=%b, required 0100/2/1", gnt, gnt_id, busy);
        end
        tick(4'b0100);
        tick(4'b0100);
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL single_hold: gnt=%b required 0100", gnt);
        end
        tick(4'b0000);
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt !== exp_gnt()) begin
            bad++;
            $display("FAIL single_release: gnt=%b busy=%b, required 0000/0", gnt, busy);
        end
    endtask

    task automatic test_round_robin();
        int         order[$];
        int         exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        logic [3:0] prev_g;
        bit         seen_busy;
        apply_reset();
        prev_g    = 4'b0000;
        seen_busy = 1'b0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_hold == 2) r[m_owner] = 1'b0;
            tick(r);
            total++;
            if (gnt !== exp_gnt()) begin
                bad++;
                $display("FAIL rr_gnt cycle %0d: gnt=%b required %b", c, gnt, exp_gnt());
            end
            if (seen_busy) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL rr_no_idle cycle %0d: busy=%b required 1", c, busy);
                end
            end
            if (busy === 1'b1) seen_busy = 1'b1;
            if (gnt !== prev_g && gnt !== 4'b0000) begin
                for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
            end
            prev_g = gnt;
        end
        total++;
        if (order.size() != 5) begin
            bad++;
            $display("FAIL rr_order_len: got %0d grants, required 5", order.size());
        end
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            total++;
            if (order[i] != exp_order[i]) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_timeout_contention();
        apply_reset();
        for (int t = 1; t <= MAX_HOLD; t++) begin
            tick(4'b0011);
            total++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL to_cont_hold cycle %0d: gnt=%b timeout=%b, required 0001/0", t, gnt, timeout);
            end
        end
        tick(4'b0011);
        total++;
        if (gnt !== 4'b0010 || timeout !== 1'b1 || m_to !== 1'b1) begin
            bad++;
            $display("FAIL to_cont_switch: gnt=%b timeout=%b, required 0010/1", gnt, timeout);
        end
        tick(4'b0011);
        total++;
        if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_cont_pulse_width: gnt=%b timeout=%b, required 0010/0", gnt, timeout);
        end
    endtask

    task automatic test_timeout_alone();
        int pulses = 0;
        apply_reset();
        for (int t = 1; t <= 20; t++) begin
            tick(4'b0001);
            if (timeout === 1'b1) pulses++;
            total++;
            if (gnt !== 4'b0001 || timeout !== ((t == 9) || (t == 17)) || timeout !== m_to) begin
                bad++;
                $display("FAIL to_alone cycle %0d: gnt=%b timeout=%b, required 0001/%0d", t, gnt, timeout, (t == 9) || (t == 17));
            end
        end
        total++;
        if (pulses != 2) begin
            bad++;
            $display("FAIL to_alone_count: got %0d pulses required 2", pulses);
        end
        tick(4'b0000);
        tick(4'b0011);
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL to_alone_ptr: gnt=%b required 0010", gnt);
        end
    endtask

    task automatic test_release_beats_timeout();
        apply_reset();
        for (int t = 1; t <= MAX_HOLD; t++) tick(4'b0001);
        tick(4'b0010);
        total++;
        if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL release_vs_timeout: gnt=%b timeout=%b, required 0010/0", gnt, timeout);
        end
    endtask

    task automatic test_random();
        logic [3:0] cur = 4'b0000;
        logic [3:0] g;
        bit         prev_to = 1'b0;
        apply_reset();
        for (int c = 0; c < 100; c++) begin
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
            tick(cur);
            g = gnt;
            total++;
            if (gnt !== exp_gnt() || busy !== (m_owner >= 0) || timeout !== m_to) begin
                bad++;
                $display("FAIL rand_model cycle %0d: gnt=%b busy=%b timeout=%b, required %b/%0d/%b", c, gnt, busy, timeout, exp_gnt(), m_owner >= 0, m_to);
            end
            if (m_owner >= 0) begin
                total++;
                if (gnt_id !== 2'(m_owner)) begin
                    bad++;
                    $display("FAIL rand_gnt_id cycle %0d: gnt_id=%0d required %0d", c, gnt_id, m_owner);
                end
            end
            total++;
            if ((g & (g - 4'd1)) !== 4'b0000 || (g & ~cur) !== 4'b0000 || (prev_to && timeout)) begin
                bad++;
                $display("FAIL rand_invariant cycle %0d: gnt=%b req=%b timeout=%b prev_timeout=%b", c, g, cur, timeout, prev_to);
            end
            prev_to = timeout;
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_timeout_contention();
        test_timeout_alone();
        test_release_beats_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
